// File: rtl/clk_div_gen.sv
// clk_div_gen: one binary counter on clk_32f feeding registered power-of-two
// divided clocks, per-tap rise/fall strobes, fixed clk_4f/clk_2f/clk_f taps,
// a glitch-free runtime-selectable clock and a lock indicator.
module clk_div_gen #(
  parameter int CNT_W    = 5,
  parameter int SEL_W    = 3,
  parameter int SEL_INIT = 2
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] div_clk,
  output logic [CNT_W-1:0] rise_stb,
  output logic [CNT_W-1:0] fall_stb,
  output logic             clk_4f,
  output logic             clk_2f,
  output logic             clk_f,
  output logic             clk_sel,
  output logic             sel_ack,
  output logic             locked
);

  // Tap count expressed in sel's width plus one bit so the range test is exact.
  localparam logic [SEL_W:0]   SEL_LIM    = (SEL_W + 1)'(CNT_W);
  localparam logic [SEL_W-1:0] SEL_INIT_V = SEL_W'(SEL_INIT);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_rise;
  logic [CNT_W-1:0] r_fall;
  logic [SEL_W-1:0] r_sel_q;
  logic             r_clk_sel;
  logic             r_sel_ack;
  logic             r_locked;

  logic [CNT_W-1:0] w_nxt;
  logic             w_wrap;
  logic             w_switch;
  logic             w_sel_ok;
  logic [SEL_W-1:0] w_sel_next;
  logic             w_tap;

  // Next counter value: clear wins over enable, otherwise hold.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    w_nxt = r_cnt;
    if (sync_clr) begin
      w_nxt = '0;
    end else if (en) begin
      w_nxt = r_cnt + 1'b1;
    end
  end

  // The selection may only move where every tap is about to be low: at a
  // wrap or on a synchronous clear, so the selected clock can never runt.
  assign w_wrap     = en & (&r_cnt);
  assign w_switch   = sync_clr | w_wrap;
  assign w_sel_ok   = ({1'b0, sel} < SEL_LIM) && (sel != r_sel_q);
  assign w_sel_next = (w_switch && w_sel_ok) ? sel : r_sel_q;

  // Pick the next value of the tap that will be selected after this edge.
  always_comb begin
    w_tap = 1'b0;
    for (int k = 0; k < CNT_W; k++) begin
      if (w_sel_next == SEL_W'(k)) begin
        w_tap = w_nxt[k];
      end
    end
  end

  // Counter, strobes, selection and lock state, all on the single clock.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_sel_q   <= SEL_INIT_V;
      r_clk_sel <= 1'b0;
      r_sel_ack <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      r_cnt     <= w_nxt;
      r_rise    <= w_nxt & ~r_cnt;
      r_fall    <= ~w_nxt & r_cnt;
      r_sel_q   <= w_sel_next;
      r_clk_sel <= w_tap;
      r_sel_ack <= w_switch & w_sel_ok;
      if (sync_clr) begin
        r_locked <= 1'b0;
      end else if (w_wrap) begin
        r_locked <= 1'b1;
      end
    end
  end

  assign div_clk  = r_cnt;
  assign rise_stb = r_rise;
  assign fall_stb = r_fall;
  assign clk_4f   = r_cnt[2];
  assign clk_2f   = r_cnt[3];
  assign clk_f    = r_cnt[4];
  assign clk_sel  = r_clk_sel;
  assign sel_ack  = r_sel_ack;
  assign locked   = r_locked;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: scoreboard bench for clk_div_gen with CNT_W=5.
// Each driven cycle pushes the model's expected outputs; they are popped and
// compared just after the clock edge that produces them.
module tb_clk_div_gen;

  typedef struct {
    logic [4:0] div;
    logic [4:0] rise;
    logic [4:0] fall;
    logic       csel;
    logic       ack;
    logic       lock;
  } exp_t;

  logic       clk_32f;
  logic       reset;
  logic       en;
  logic       sync_clr;
  logic [2:0] sel;
  logic [4:0] div_clk;
  logic [4:0] rise_stb;
  logic [4:0] fall_stb;
  logic       clk_4f;
  logic       clk_2f;
  logic       clk_f;
  logic       clk_sel;
  logic       sel_ack;
  logic       locked;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  // Reference model state.
  int   m_cnt;
  int   m_sel;
  logic m_lock;

  // Runt detector on clk_sel.
  bit   mon;
  int   run;

  clk_div_gen #(.CNT_W(5), .SEL_W(3), .SEL_INIT(2)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .en      (en),
    .sync_clr(sync_clr),
    .sel     (sel),
    .div_clk (div_clk),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb),
    .clk_4f  (clk_4f),
    .clk_2f  (clk_2f),
    .clk_f   (clk_f),
    .clk_sel (clk_sel),
    .sel_ack (sel_ack),
    .locked  (locked)
  );

  initial begin
    clk_32f = 1'b0;
    forever #5 clk_32f = ~clk_32f;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt  = 0;
    m_sel  = 2;
    m_lock = 1'b0;
    sb.delete();
  endtask

  // Drive one cycle of stimulus, predict, wait for the edge, compare.
  task automatic cyc(input logic e, input logic c, input logic [2:0] s);
    exp_t       x;
    exp_t       got;
    int         n;
    int         old;
    logic [4:0] nv;
    logic [4:0] ov;
    bit         sw;
    bit         ak;
    en = e; sync_clr = c; sel = s;
    old = m_cnt;
    if (c)      n = 0;
    else if (e) n = (m_cnt + 1) % 32;
    else        n = m_cnt;
    sw = c || (e && m_cnt == 31);
    ak = sw && (int'(s) < 5) && (int'(s) != m_sel);
    if (ak) m_sel = int'(s);
    if (c) m_lock = 1'b0;
    else if (e && m_cnt == 31) m_lock = 1'b1;
    nv = n[4:0];
    ov = old[4:0];
    x.div  = nv;
    x.rise = nv & ~ov;
    x.fall = ~nv & ov;
    x.csel = nv[m_sel];
    x.ack  = ak;
    x.lock = m_lock;
    m_cnt  = n;
    sb.push_back(x);
    @(posedge clk_32f);
    #1;
    got = sb.pop_front();
    check("div",  div_clk,  got.div);
    check("rise", rise_stb, got.rise);
    check("fall", fall_stb, got.fall);
    check("c4f",  clk_4f,   got.div[2]);
    check("c2f",  clk_2f,   got.div[3]);
    check("cf",   clk_f,    got.div[4]);
    check("csel", clk_sel,  got.csel);
    check("ack",  sel_ack,  got.ack);
    check("lock", locked,   got.lock);
    if (mon) begin
      if (clk_sel) run++;
      else begin
        if (run > 0) check("runt", run >= 4, 1);
        run = 0;
      end
    end
  endtask

  task automatic goto(input int tgt, input logic [2:0] s);
    int guard = 0;
    while (m_cnt != tgt && guard < 64) begin
      cyc(1'b1, 1'b0, s);
      guard++;
    end
    check("goto", div_clk, tgt);
  endtask

  // First 40 enabled edges after reset release: tap timing and lock point.
  task automatic startup(input logic [2:0] s);
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b1, 1'b0, s);
      if (i == 3)  check("c4f_pre",   clk_4f, 0);
      if (i == 4)  check("c4f_first", {clk_4f, rise_stb[2]}, 2'b11);
      if (i == 7)  check("c2f_pre",   clk_2f, 0);
      if (i == 8)  check("c2f_first", {clk_2f, rise_stb[3]}, 2'b11);
      if (i == 12) check("c4f_per",   rise_stb[2], 1);
      if (i == 15) check("cf_pre",    clk_f, 0);
      if (i == 16) check("cf_first",  {clk_f, rise_stb[4]}, 2'b11);
      if (i == 31) check("lock_pre",  locked, 0);
      if (i == 32) check("lock_32",   {locked, fall_stb}, 6'b111111);
      if (i == 36) check("csel_tap2", clk_sel, 1);
    end
  endtask

  initial begin
    int ack_cnt;
    mon = 0; run = 0;
    en = 0; sync_clr = 0; sel = 3'd2;
    reset = 1'b0;
    model_reset();
    #12;
    check("rst_all", {div_clk, rise_stb, fall_stb, clk_4f, clk_2f, clk_f,
                      clk_sel, sel_ack, locked}, 0);
    @(negedge clk_32f);
    reset = 1'b1;

    // Scenario 1: free-running startup.
    startup(3'd2);

    // Scenario 2: request tap 4 at cnt=10; switch only at the wrap.
    goto(10, 3'd2);
    mon = 1; run = 0;
    for (int i = 1; i <= 22; i++) begin
      cyc(1'b1, 1'b0, 3'd4);
      if (i == 22) check("s2_ack", {sel_ack, clk_sel, div_clk}, {2'b10, 5'd0});
    end
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b1, 1'b0, 3'd4);
      if (i == 16) check("s2_cf", clk_sel, 1);
    end
    mon = 0;

    // Scenario 3: hold at cnt=13 for 7 cycles.
    goto(13, 3'd4);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 3'd4);
    check("s3_hold", {div_clk, locked}, {5'd13, 1'b1});
    cyc(1'b1, 1'b0, 3'd4);
    check("s3_resume", div_clk, 14);

    // Scenario 4: sync_clr at cnt=20 with sel=3 pending.
    goto(20, 3'd3);
    check("s4_lock_pre", locked, 1);
    cyc(1'b1, 1'b1, 3'd3);
    check("s4_clr", {div_clk, fall_stb, locked, sel_ack, clk_sel},
                    {5'd0, 5'b10100, 1'b0, 1'b1, 1'b0});
    for (int i = 1; i <= 32; i++) begin
      cyc(1'b1, 1'b0, 3'd3);
      if (i == 8)  check("s4_tap3", clk_sel, 1);
      if (i == 31) check("s4_lock31", locked, 0);
      if (i == 32) check("s4_lock32", locked, 1);
    end

    // Scenario 5: out-of-range sel across two wraps.
    ack_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      cyc(1'b1, 1'b0, 3'd7);
      ack_cnt += int'(sel_ack);
    end
    check("s5_noack", ack_cnt, 0);

    // Scenario 6: asynchronous reset between edges at cnt=27.
    goto(27, 3'd7);
    #2 reset = 1'b0;
    #1;
    check("s6_async", {div_clk, rise_stb, fall_stb, clk_4f, clk_2f, clk_f,
                       clk_sel, sel_ack, locked}, 0);
    model_reset();
    @(negedge clk_32f);
    reset = 1'b1;
    startup(3'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
